// File: rtl/ahb_pkg.sv
// Shared AHB encodings, responder FSM state type and byte-lane mask helper
// for the SRAM responder.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Address bits below the access size are ignored, so misaligned halves
    // and words land on their naturally aligned lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr;
            HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_bytewrite.sv
// Word-organised SRAM with per-byte write enables, synchronous write and
// combinational read.
module sram_bytewrite #(
    parameter int P_DEPTH = 256,
    parameter int P_AW    = 8
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [3:0]      i_be,
    input  logic [P_AW-1:0] i_addr,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata
);

    logic [31:0] r_mem [P_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder with programmable wait states and two-cycle ERROR for
// illegal sizes. Define AHB_SLV_ALIGN_CHECK_EN to also reject misaligned accesses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int P_SLV_ID        = 0,
    parameter int P_SIZE_IN_BYTES = 1024,
    parameter int P_DELAY         = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    output logic        HREADYout,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic [15:0] HSPLIT,
    output state_t      o_dbg_state
);

    localparam int LP_AW  = $clog2(P_SIZE_IN_BYTES);
    localparam int LP_WAW = LP_AW - 2;
    localparam logic [3:0] LP_CNT_INIT = (P_DELAY > 0) ? 4'(P_DELAY - 1) : 4'd0;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [LP_AW-1:0] r_addr_q;
    logic [2:0]       r_size_q;
    logic             r_write_q;
    logic             r_err_q;
    logic             r_hreadyout;
    logic [1:0]       r_hresp;

    logic             w_accept;
    logic             w_err;
    logic             w_we;
    logic [3:0]       w_be;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // A new address phase can only land while our own data phase is not stalling.
    assign w_accept = HSEL & HREADYin & HTRANS[1] &
                      ((r_state == ST_IDLE) | (r_state == ST_LAST) | (r_state == ST_ERR2));

`ifdef AHB_SLV_ALIGN_CHECK_EN
    assign w_err = (HSIZE > HSIZE_WORD) |
                   ((HSIZE == HSIZE_HALF) & HADDR[0]) |
                   ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));
`else
    assign w_err = (HSIZE > HSIZE_WORD);
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr_q    <= '0;
            r_size_q    <= HSIZE_BYTE;
            r_write_q   <= 1'b0;
            r_err_q     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE, ST_LAST, ST_ERR2: begin
                    if (w_accept) begin
                        r_addr_q  <= HADDR[LP_AW-1:0];
                        r_size_q  <= HSIZE;
                        r_write_q <= HWRITE;
                        r_err_q   <= w_err;
                        if (w_err) begin
                            r_state     <= ST_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end else if (P_DELAY == 0) begin
                            r_state     <= ST_LAST;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= HRESP_OKAY;
                        end else begin
                            r_state     <= ST_WAIT;
                            r_cnt       <= LP_CNT_INIT;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_OKAY;
                        end
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_LAST;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // A write still pending at a reset edge is dropped.
    assign w_we = (r_state == ST_LAST) & r_write_q & ~r_err_q & ~HRESET;
    assign w_be = lane_mask(r_size_q, r_addr_q[1:0]);

    sram_bytewrite #(
        .P_DEPTH (P_SIZE_IN_BYTES / 4),
        .P_AW    (LP_WAW)
    ) u_sram (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (r_addr_q[LP_AW-1:2]),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

    assign HREADYout   = r_hreadyout;
    assign HRESP       = r_hresp;
    assign HRDATA      = ((r_state == ST_LAST) && !r_write_q) ? w_rdata : 32'h0;
    assign HSPLIT      = 16'h0000;
    assign o_dbg_state = r_state;

    assign w_unused = ^{HBURST, HTRANS[0], HADDR[31:LP_AW], (P_SLV_ID != 0)};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a zero-wait and a three-wait instance
// driven by a table of single transfers plus hand-written pipeline/reset sequences.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel1;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    wire         rdy0, rdy1;
    logic [1:0]  resp0, resp1;
    logic [31:0] rd0, rd1;
    logic [15:0] sp0, sp1;
    state_t      st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.P_SLV_ID(0), .P_SIZE_IN_BYTES(1024), .P_DELAY(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYin(rdy0), .HREADYout(rdy0), .HRESP(resp0), .HRDATA(rd0),
        .HSPLIT(sp0), .o_dbg_state(st0)
    );

    ahb_sram_slave #(.P_SLV_ID(1), .P_SIZE_IN_BYTES(1024), .P_DELAY(3)) u_dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYin(rdy1), .HREADYout(rdy1), .HRESP(resp1), .HRDATA(rd1),
        .HSPLIT(sp1), .o_dbg_state(st1)
    );

    typedef struct {
        int          sel;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_waits;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic cur_rdy(input int sel);
        return (sel == 1) ? rdy1 : rdy0;
    endfunction

    function automatic logic [1:0] cur_resp(input int sel);
        return (sel == 1) ? resp1 : resp0;
    endfunction

    function automatic logic [31:0] cur_rd(input int sel);
        return (sel == 1) ? rd1 : rd0;
    endfunction

    task automatic bus_idle();
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; hburst = 3'b000;
    endtask

    // Entered just after a rising edge; returns just after the closing edge.
    task automatic xfer(input int sel, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int waits,
                        output logic [1:0] low_resp, output logic [1:0] fin_resp,
                        output logic timeout);
        hsel0 = (sel == 0); hsel1 = (sel == 1);
        haddr = addr; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = sz; hburst = 3'b000;
        @(posedge clk); #1;
        bus_idle();
        hwdata = wdata;
        waits = 0; low_resp = 2'b00; fin_resp = 2'b00; rdata = 32'h0; timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cur_rdy(sel)) begin
                rdata    = cur_rd(sel);
                fin_resp = cur_resp(sel);
                timeout  = 1'b0;
                break;
            end
            if (waits == 0) low_resp = cur_resp(sel);
            waits++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rdata;
        int          waits;
        logic [1:0]  low_resp, fin_resp;
        logic        timeout;

        vq.push_back('{0, 1'b1, HSIZE_WORD, 32'h010, 32'hDEADBEEF, 32'h0,        0, HRESP_OKAY});
        vq.push_back('{0, 1'b0, HSIZE_WORD, 32'h010, 32'h0,        32'hDEADBEEF, 0, HRESP_OKAY});
        vq.push_back('{0, 1'b1, HSIZE_WORD, 32'h020, 32'h00000000, 32'h0,        0, HRESP_OKAY});
        vq.push_back('{0, 1'b1, HSIZE_BYTE, 32'h021, 32'h00001100, 32'h0,        0, HRESP_OKAY});
        vq.push_back('{0, 1'b1, HSIZE_BYTE, 32'h022, 32'h00220000, 32'h0,        0, HRESP_OKAY});
        vq.push_back('{0, 1'b0, HSIZE_WORD, 32'h020, 32'h0,        32'h00221100, 0, HRESP_OKAY});
        vq.push_back('{0, 1'b1, HSIZE_WORD, 32'h030, 32'h12345678, 32'h0,        0, HRESP_OKAY});
        vq.push_back('{0, 1'b1, 3'b011,     32'h030, 32'h5555AAAA, 32'h0,        1, HRESP_ERROR});
        vq.push_back('{0, 1'b0, HSIZE_WORD, 32'h030, 32'h0,        32'h12345678, 0, HRESP_OKAY});
        vq.push_back('{0, 1'b1, HSIZE_WORD, 32'h050, 32'h11111111, 32'h0,        0, HRESP_OKAY});
        vq.push_back('{0, 1'b1, HSIZE_HALF, 32'h052, 32'hABCD0000, 32'h0,        0, HRESP_OKAY});
        vq.push_back('{0, 1'b0, HSIZE_WORD, 32'h050, 32'h0,        32'hABCD1111, 0, HRESP_OKAY});
        vq.push_back('{0, 1'b1, HSIZE_WORD, 32'h040, 32'h00000000, 32'h0,        0, HRESP_OKAY});
`ifdef AHB_SLV_ALIGN_CHECK_EN
        vq.push_back('{0, 1'b1, HSIZE_WORD, 32'h042, 32'hCAFEF00D, 32'h0,        1, HRESP_ERROR});
        vq.push_back('{0, 1'b0, HSIZE_WORD, 32'h040, 32'h0,        32'h00000000, 0, HRESP_OKAY});
`else
        vq.push_back('{0, 1'b1, HSIZE_WORD, 32'h042, 32'hCAFEF00D, 32'h0,        0, HRESP_OKAY});
        vq.push_back('{0, 1'b0, HSIZE_WORD, 32'h040, 32'h0,        32'hCAFEF00D, 0, HRESP_OKAY});
`endif
        vq.push_back('{0, 1'b0, HSIZE_WORD, 32'h410, 32'h0,        32'hDEADBEEF, 0, HRESP_OKAY});
        vq.push_back('{0, 1'b0, HSIZE_BYTE, 32'h013, 32'h0,        32'hDEADBEEF, 0, HRESP_OKAY});
        vq.push_back('{1, 1'b1, HSIZE_WORD, 32'h008, 32'hA5A5A5A5, 32'h0,        3, HRESP_OKAY});
        vq.push_back('{1, 1'b0, HSIZE_WORD, 32'h008, 32'h0,        32'hA5A5A5A5, 3, HRESP_OKAY});
        vq.push_back('{1, 1'b1, 3'b100,     32'h008, 32'h0,        32'h0,        1, HRESP_ERROR});
        vq.push_back('{1, 1'b0, HSIZE_HALF, 32'h00A, 32'h0,        32'hA5A5A5A5, 3, HRESP_OKAY});
        vq.push_back('{1, 1'b1, HSIZE_WORD, 32'h060, 32'h13572468, 32'h0,        3, HRESP_OKAY});

        // Clock/reset
        rst = 1'b1; haddr = 32'h0; hwdata = 32'h0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready0", 32'(rdy0), 32'h1);
        check("rst_resp0",  32'(resp0), 32'(HRESP_OKAY));
        check("rst_rdata0", rd0, 32'h0);
        check("rst_state0", 32'(st0), 32'(ST_IDLE));
        check("rst_ready1", 32'(rdy1), 32'h1);
        check("rst_split1", 32'(sp1), 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            xfer(vq[i].sel, vq[i].wr, vq[i].sz, vq[i].addr, vq[i].wdata,
                 rdata, waits, low_resp, fin_resp, timeout);
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'h0);
            check($sformatf("vec%0d_waits", i), 32'(waits), 32'(vq[i].exp_waits));
            check($sformatf("vec%0d_resp", i), 32'(fin_resp), 32'(vq[i].exp_resp));
            if (vq[i].exp_waits > 0)
                check($sformatf("vec%0d_low_resp", i), 32'(low_resp), 32'(vq[i].exp_resp));
            if (!vq[i].wr)
                check($sformatf("vec%0d_rdata", i), rdata, vq[i].exp_rd);
        end

        @(negedge clk);
        check("idle_rdata0", rd0, 32'h0);
        check("idle_state1", 32'(st1), 32'(ST_IDLE));
        @(posedge clk); #1;

        // Back-to-back write then read of the same word, no bubble.
        hsel0 = 1'b1; haddr = 32'h070; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hwdata = 32'h0BADF00D;
        haddr = 32'h070; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
        @(negedge clk);
        check("b2b_wr_ready", 32'(rdy0), 32'h1);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("b2b_rd_ready", 32'(rdy0), 32'h1);
        check("b2b_rd_data", rd0, 32'h0BADF00D);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_after_state", 32'(st0), 32'(ST_IDLE));
        @(posedge clk); #1;

        // Reset during a WAIT cycle of a write: write discarded.
        hsel1 = 1'b1; haddr = 32'h060; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rstw_in_wait_ready", 32'(rdy1), 32'h0);
        check("rstw_in_wait_state", 32'(st1), 32'(ST_WAIT));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_ready", 32'(rdy1), 32'h1);
        check("rstw_resp", 32'(resp1), 32'(HRESP_OKAY));
        check("rstw_state", 32'(st1), 32'(ST_IDLE));
        @(posedge clk); #1;
        xfer(1, 1'b0, HSIZE_WORD, 32'h060, 32'h0, rdata, waits, low_resp, fin_resp, timeout);
        check("rstw_rd_timeout", 32'(timeout), 32'h0);
        check("rstw_rd_waits", 32'(waits), 32'd3);
        check("rstw_rd_data", rdata, 32'h13572468);
        xfer(0, 1'b0, HSIZE_WORD, 32'h010, 32'h0, rdata, waits, low_resp, fin_resp, timeout);
        check("rst_keeps_mem", rdata, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
